// File: rtl/sha256_wntz_chain_if.sv
// Request and response channels of the Winternitz hash-chain sequencer.
interface sha256_wntz_chain_if;
  logic         req_valid;
  logic         req_ready;
  logic [175:0] req_prefix;
  logic [255:0] req_seed;
  logic [7:0]   req_start;
  logic [3:0]   req_w;
  logic         req_n_mode;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_digest;
  logic         rsp_error;

  modport master (
    output req_valid, req_prefix, req_seed, req_start, req_w, req_n_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_digest, rsp_error
  );

  modport slave (
    input  req_valid, req_prefix, req_seed, req_start, req_w, req_n_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_digest, rsp_error
  );
endinterface

// File: rtl/sha256_wntz_chain.sv
// Winternitz hash-chain sequencer: queues chain requests and steps a sha256_core
// through y <- H(prefix || j || y) until j reaches 2^w-1, then returns y.
module sha256_wntz_chain #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [3:0]  W_SUPPORT   = 4'b1111
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      zeroize,
  sha256_wntz_chain_if.slave        host,
  output logic                      core_init,
  output logic                      core_mode,
  output logic [511:0]              core_block,
  input  logic                      core_ready,
  input  logic [255:0]              core_digest,
  input  logic                      core_digest_valid,
  output logic                      busy
);

  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [255:0] MASK24 = {{192{1'b1}}, 64'h0};

  typedef struct packed {
    logic [175:0] prefix;
    logic [255:0] seed;
    logic [7:0]   start;
    logic [3:0]   w;
    logic         n32;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

  logic          rst;
  req_t          mem [QUEUE_DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  state_t        state;
  logic [175:0]  prefix_r;
  logic [255:0]  y_r;
  logic [7:0]    j_r, j_next, end_idx;
  logic [3:0]    w_r;
  logic          n32_r;
  logic          valid_q;
  logic          w_ok, req_err, dv_rise;
  logic [255:0]  digest_m;
  logic          rsp_valid_r, rsp_error_r;
  logic [255:0]  rsp_digest_r;

  assign rst   = !reset_n || zeroize;
  assign full  = (count == CW'(QUEUE_DEPTH));
  assign empty = (count == '0);
  assign push  = host.req_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign head  = mem[rd_ptr];

  assign host.req_ready  = !full;
  assign host.rsp_valid  = rsp_valid_r;
  assign host.rsp_digest = rsp_digest_r;
  assign host.rsp_error  = rsp_error_r;

  assign core_mode = 1'b1;
  assign core_init = (state == S_ISSUE) && core_ready;
  assign busy      = (state != S_IDLE) || !empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{prefix: host.req_prefix, seed: host.req_seed,
                               start: host.req_start, w: host.req_w, n32: host.req_n_mode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Only the four legal w values map to an end index; anything else is an error.
  always_comb begin
    w_ok    = 1'b0;
    end_idx = '0;
    case (w_r)
      4'd1:    begin w_ok = W_SUPPORT[0]; end_idx = 8'd1;   end
      4'd2:    begin w_ok = W_SUPPORT[1]; end_idx = 8'd3;   end
      4'd4:    begin w_ok = W_SUPPORT[2]; end_idx = 8'd15;  end
      4'd8:    begin w_ok = W_SUPPORT[3]; end_idx = 8'd255; end
      default: begin w_ok = 1'b0;         end_idx = 8'd0;   end
    endcase
  end

  assign req_err  = !w_ok || (j_r > end_idx);
  assign j_next   = j_r + 8'd1;
  assign dv_rise  = core_digest_valid && !valid_q;
  assign digest_m = n32_r ? core_digest : (core_digest & MASK24);

  always_comb begin
    core_block = '0;
    if (state == S_ISSUE || state == S_WAIT)
      core_block = n32_r ? {prefix_r, j_r, y_r, 8'h80, 64'd440}
                         : {prefix_r, j_r, y_r[255:64], 8'h80, 64'h0, 64'd376};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      prefix_r     <= '0;
      y_r          <= '0;
      j_r          <= '0;
      w_r          <= '0;
      n32_r        <= 1'b0;
      valid_q      <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_digest_r <= '0;
      rsp_error_r  <= 1'b0;
    end else begin
      valid_q <= core_digest_valid;
      case (state)
        S_IDLE: if (!empty) begin
          prefix_r <= head.prefix;
          y_r      <= head.n32 ? head.seed : (head.seed & MASK24);
          j_r      <= head.start;
          w_r      <= head.w;
          n32_r    <= head.n32;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (req_err) begin
            rsp_valid_r  <= 1'b1;
            rsp_error_r  <= 1'b1;
            rsp_digest_r <= '0;
            state        <= S_RESP;
          end else if (j_r == end_idx) begin
            rsp_valid_r  <= 1'b1;
            rsp_error_r  <= 1'b0;
            rsp_digest_r <= y_r;
            state        <= S_RESP;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: if (core_ready) state <= S_WAIT;
        S_WAIT: if (dv_rise) begin
          y_r <= digest_m;
          j_r <= j_next;
          if (j_next == end_idx) begin
            rsp_valid_r  <= 1'b1;
            rsp_error_r  <= 1'b0;
            rsp_digest_r <= digest_m;
            state        <= S_RESP;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_RESP: if (host.rsp_ready) begin
          rsp_valid_r <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_wntz_chain.sv
// Directed bench for sha256_wntz_chain with a behavioural core that returns a
// deterministic mixing function of the block after a fixed latency.
module tb_sha256_wntz_chain;

  localparam int unsigned LAT = 3;
  localparam logic [255:0] MASK24 = {{192{1'b1}}, 64'h0};

  logic         clk;
  logic         reset_n;
  logic         zeroize;
  logic         core_init, core_mode, core_ready, core_digest_valid, busy;
  logic [511:0] core_block;
  logic [255:0] core_digest;

  sha256_wntz_chain_if bus ();

  sha256_wntz_chain #(.QUEUE_DEPTH(2), .W_SUPPORT(4'b1111)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .zeroize           (zeroize),
    .host              (bus),
    .core_init         (core_init),
    .core_mode         (core_mode),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .busy              (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   jlog [$];
  logic [511:0] blog [$];
  logic         ready_block = 1'b0;
  int unsigned  cm_cnt = 0, cm_hold = 0;
  logic [255:0] cm_result = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] mix(input logic [511:0] b);
    logic [255:0] x;
    x = b[511:256] ^ {b[254:0], b[255]};
    x = x + 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    return {x[127:0], x[255:128]} ^ b[255:0];
  endfunction

  function automatic logic [511:0] mk_blk(input logic [175:0] p, input logic [7:0] j,
                                          input logic [255:0] y, input logic n32);
    return n32 ? {p, j, y, 8'h80, 64'd440}
               : {p, j, y[255:64], 8'h80, 64'h0, 64'd376};
  endfunction

  function automatic logic [255:0] chain(input logic [175:0] p, input logic [255:0] seed,
                                         input int unsigned j0, input int unsigned w,
                                         input logic n32);
    logic [255:0] y;
    int unsigned  last;
    y    = n32 ? seed : (seed & MASK24);
    last = (1 << w) - 1;
    for (int unsigned j = j0; j < last; j++) begin
      y = mix(mk_blk(p, 8'(j), y, n32));
      if (!n32) y = y & MASK24;
    end
    return y;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: digest valid is held 3 cycles so a level-sensitive capture
  // would see the stale value again in the following WAIT.
  initial begin
    core_ready        = 1'b1;
    core_digest       = '0;
    core_digest_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cm_hold > 0) begin
        cm_hold--;
        if (cm_hold == 0) core_digest_valid = 1'b0;
      end
      if (cm_cnt > 0) begin
        cm_cnt--;
        if (cm_cnt == 0) begin
          core_digest       = cm_result;
          core_digest_valid = 1'b1;
          cm_hold           = 3;
        end
      end
      core_ready = !ready_block && (cm_cnt == 0);
      #1;
      if (core_init === 1'b1) begin
        jlog.push_back(core_block[335:328]);
        blog.push_back(core_block);
        cm_result = mix(core_block);
        cm_cnt    = LAT;
      end
    end
  end

  task automatic send(input logic [175:0] p, input logic [255:0] s, input logic [7:0] j0,
                      input logic [3:0] w, input logic n32);
    int k;
    @(negedge clk);
    bus.req_prefix = p;
    bus.req_seed   = s;
    bus.req_start  = j0;
    bus.req_w      = w;
    bus.req_n_mode = n32;
    bus.req_valid  = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check("req_accept_timeout", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [255:0] d, output logic e);
    int k;
    k = 0;
    while (!bus.rsp_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", bus.rsp_valid, 1);
    d = bus.rsp_digest;
    e = bus.rsp_error;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [175:0] p1, p2;
  logic [255:0] s1, s2, s3, d;
  logic         e;

  initial begin
    p1 = {11{16'hA5C3}};
    p2 = {22{8'h3C}};
    s1 = {8{32'h01234567}};
    s2 = {4{64'hDEADBEEFCAFEF00D}};
    s3 = {16{16'h5A17}};
    reset_n = 1'b0;
    zeroize = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_prefix = '0;
    bus.req_seed = '0;
    bus.req_start = '0;
    bus.req_w = '0;
    bus.req_n_mode = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_core_init", core_init, 0);
    check("reset_core_block", core_block, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_digest", bus.rsp_digest, 0);
    check("reset_rsp_error", bus.rsp_error, 0);
    check("reset_busy", busy, 0);
    check("core_mode", core_mode, 1);

    // w=4, n32, full chain of 15 hashes
    jlog.delete(); blog.delete();
    send(p1, s1, 8'd0, 4'd4, 1'b1);
    get_rsp(d, e);
    check("w4_init_count", jlog.size(), 15);
    for (int i = 0; i < 15 && i < jlog.size(); i++) check("w4_j", jlog[i], i);
    check("w4_tail", blog[0][71:0], {8'h80, 64'd440});
    check("w4_digest", d, chain(p1, s1, 0, 4, 1'b1));
    check("w4_error", e, 0);

    // w=8, n24, j0=250: five hashes, low 64 bits masked
    jlog.delete(); blog.delete();
    send(p2, s2, 8'd250, 4'd8, 1'b0);
    get_rsp(d, e);
    check("w8_init_count", jlog.size(), 5);
    for (int i = 0; i < 5 && i < jlog.size(); i++) check("w8_j", jlog[i], 250 + i);
    check("w8_tail", blog[4][135:0], {8'h80, 64'h0, 64'd376});
    check("w8_low_zero", d[63:0], 0);
    check("w8_digest", d, chain(p2, s2, 250, 8, 1'b0));
    check("w8_error", e, 0);

    // zero-hash request: response two cycles after acceptance
    jlog.delete();
    send(p1, s2, 8'd3, 4'd2, 1'b0);
    check("zh_valid_c", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("zh_valid_c1", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("zh_valid_c2", bus.rsp_valid, 1);
    get_rsp(d, e);
    check("zh_digest", d, s2 & MASK24);
    check("zh_error", e, 0);
    check("zh_no_init", jlog.size(), 0);

    send(p1, s1, 8'd0, 4'd3, 1'b1);
    get_rsp(d, e);
    check("w3_error", e, 1);
    check("w3_digest", d, 0);
    send(p1, s1, 8'd4, 4'd2, 1'b1);
    get_rsp(d, e);
    check("j0_big_error", e, 1);
    check("j0_big_digest", d, 0);
    check("err_no_init", jlog.size(), 0);

    // queue fills while the response channel is stalled
    send(p1, s1, 8'd1, 4'd1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("q_first_rsp", bus.rsp_valid, 1);
    send(p2, s2, 8'd3, 4'd2, 1'b0);
    check("q_ready_after_1", bus.req_ready, 1);
    send(p2, s3, 8'd0, 4'd1, 1'b1);
    check("q_ready_after_2", bus.req_ready, 0);
    check("q_busy", busy, 1);
    get_rsp(d, e);
    check("q_rsp_a", d, s1);
    get_rsp(d, e);
    check("q_rsp_b", d, s2 & MASK24);
    get_rsp(d, e);
    check("q_rsp_c", d, chain(p2, s3, 0, 1, 1'b1));
    check("q_rsp_c_err", e, 0);

    // zeroize during WAIT of hash 3 of 15
    jlog.delete();
    send(p2, s3, 8'd0, 4'd4, 1'b1);
    for (int k = 0; k < 500 && jlog.size() < 3; k++) @(negedge clk);
    check("zz_reached_h3", jlog.size(), 3);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zz_busy", busy, 0);
    check("zz_rsp_valid", bus.rsp_valid, 0);
    check("zz_block", core_block, 0);
    check("zz_req_ready", bus.req_ready, 1);
    repeat (12) @(negedge clk);
    check("zz_stale_rsp", bus.rsp_valid, 0);
    check("zz_stale_busy", busy, 0);
    check("zz_no_more_init", jlog.size(), 3);
    send(p1, s2, 8'd0, 4'd2, 1'b1);
    get_rsp(d, e);
    check("zz_new_digest", d, chain(p1, s2, 0, 2, 1'b1));
    check("zz_new_inits", jlog.size(), 6);

    // core_ready held low in ISSUE
    jlog.delete();
    ready_block = 1'b1;
    send(p2, s1, 8'd0, 4'd1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      check("hold_init", core_init, 0);
      check("hold_block", core_block, mk_blk(p2, 8'd0, s1, 1'b1));
    end
    ready_block = 1'b0;
    get_rsp(d, e);
    check("hold_one_pulse", jlog.size(), 1);
    check("hold_digest", d, chain(p2, s1, 0, 1, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_wntz_chain.md
# sha256_wntz_chain

Parametrised Winternitz hash-chain sequencer that drives a `sha256_core` instance through complete chains without firmware involvement per step. It replaces the fixed single-request chain FSM of the SHA256 wrapper with the following:
- a request queue;
- arbitrary start index;
- a configurable set of supported `w` values;
- an explicit valid/ready response channel carrying the final chain value and an error flag.

It sits between the SHA256 register wrapper (or a DMA front end) and `sha256_core`.

## Interface
- `QUEUE_DEPTH`, 2: request FIFO entries, ≥1.
- `W_SUPPORT`, 4'b1111: bit k enables w = 2^k (w ∈ {1,2,4,8}).
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `zeroize` in 1: synchronous clear, same effect as reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_prefix` in 176: I‖q‖i (22 bytes).
- `req_seed` in 256: starting chain value y; n=24 uses [255:64].
- `req_start` in 8: start index j0.
- `req_w` in 4: Winternitz w.
- `req_n_mode` in 1: 1 = n32, 0 = n24.
- `core_init` out 1: one-cycle init pulse to core.
- `core_mode` out 1: constant 1 (SHA256).
- `core_block` out 512: message block.
- `core_ready` in 1: core ready.
- `core_digest` in 256: core digest.
- `core_digest_valid` in 1: core digest valid.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_digest` out 256: final y; [63:0] = 0 when n24.
- `rsp_error` out 1: request rejected.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- FIFO: `req_ready = !full`. A push occurs on `req_valid & req_ready`. A pop occurs only in IDLE. A push and a pop in the same cycle leaves the count unchanged.
- Chain: for j = j0 … 2^w−2, y ← H(prefix ‖ j ‖ y), where H is SHA256 and the result is truncated to n bytes.
  - Hash count = 2^w−1−j0.
  - j0 = 2^w−1 gives zero hashes; the response is the seed, masked.
- Block layout, MSB first:
  - n32: prefix ‖ j ‖ y[255:0] ‖ 8'h80 ‖ 64'd440.
  - n24: prefix ‖ j ‖ y[255:64] ‖ 8'h80 ‖ 64'h0 ‖ 64'd376.
- Error conditions: `req_w` is not in {1,2,4,8}, or its `W_SUPPORT` bit is clear, or j0 > 2^w−1. On error, `rsp_error`=1, `rsp_digest`=0, and no core activity occurs.
- Digest capture: captured on the rising edge of `core_digest_valid` (valid & ~valid_q). For n24, bits [63:0] are masked to 0. A `core_digest_valid` rise outside WAIT is ignored.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into working registers (prefix, y, j=j0, w, n) → CHECK.
  - CHECK (1 cycle):
    - error → RESP with `rsp_error`=1;
    - j = 2^w−1 → RESP with masked seed;
    - otherwise → ISSUE.
  - ISSUE: `core_init` = `core_ready`, so the pulse is held off until the core is ready. In the cycle `core_init`=1 → WAIT. The block is stable through ISSUE and WAIT.
  - WAIT: on digest rise, y ← masked digest and j ← j+1. If the new j = 2^w−1 → RESP, else → ISSUE.
  - RESP: `rsp_valid`=1 with the digest and error held stable until `rsp_ready`. Then → IDLE.
- j arithmetic: 8-bit. The w=8 end index is 255 and the last hash uses j=254, so the counter never wraps.
- Reset / `zeroize` (synchronous, any state including mid-chain):
  - FIFO emptied, FSM → IDLE, working y/prefix cleared, `valid_q` cleared;
  - outputs `req_ready`=1 (the cycle after), `core_init`=0, `core_block`=0, `rsp_valid`=0, `rsp_digest`=0, `rsp_error`=0, `busy`=0.
  - An in-flight core result is never reported.

## Timing
- Request accepted at edge c with FIFO empty and FSM IDLE: pop at c+1 (FSM in CHECK during c+1…c+2). ISSUE or RESP begins in the cycle after edge c+2.
- Zero-hash or error: `rsp_valid` first high 2 cycles after the acceptance cycle.
- Per hash: 1 ISSUE cycle (if `core_ready`=1) + core latency + 1 capture cycle. The next `core_init` is issued no earlier than the cycle after capture.
- `core_init` is never high for two consecutive cycles and never high outside ISSUE.
- While RESP is stalled, the FIFO keeps accepting until full. The next pop happens the cycle after the response handshake.

## Test plan
- w=4, n32, j0=0, known prefix/seed → exactly 15 `core_init` pulses with j=0…14 in block[335:328]. `rsp_digest` matches the 15-step golden model; `rsp_error`=0.
- w=8, n24, j0=250 → 5 hashes (j=250…254). Block tail = 8'h80‖64'h0‖64'd376. `rsp_digest`[63:0]=0.
- w=2, j0=3 → no `core_init`; `rsp_valid` 2 cycles after accept with the masked seed. w=3 → `rsp_error`=1, digest 0. w=2, j0=4 → error.
- `QUEUE_DEPTH`=2: three back-to-back requests with `rsp_ready`=0 → `req_ready` drops after the 2nd push. Responses return in order once `rsp_ready`=1.
- `zeroize` pulse during WAIT of hash 3/15 → next cycle IDLE, `busy`=0, `rsp_valid`=0. The later core digest rise is ignored. A new request completes correctly.
- `core_ready` held low 10 cycles in ISSUE → `core_init` stays 0, then exactly one pulse; the block is unchanged throughout.
